sisc_exec_ctrl: RTL and testbench



---
 rtl/sisc_pkg.sv | 59 +++++
 rtl/exec_alu.sv | 60 ++++++
 rtl/sisc_exec_ctrl.sv | 136 +++++++++++++
 tb/tb_sisc_exec_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared constants, state encoding and instruction layout for the SISC core.
package sisc_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ALEN   = 16;
  localparam int unsigned FLAG_W = 4;

  // Opcodes
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_RR = 4'h1;
  localparam logic [3:0] OP_ALU_RI = 4'h2;
  localparam logic [3:0] OP_BRA    = 4'h4;
  localparam logic [3:0] OP_BRR    = 4'h5;
  localparam logic [3:0] OP_BNE    = 4'h6;
  localparam logic [3:0] OP_BNR    = 4'h7;
  localparam logic [3:0] OP_HLT    = 4'hF;

  // ALU modes
  localparam logic [1:0] ALU_IDLE = 2'b00;
  localparam logic [1:0] ALU_RR   = 2'b01;
  localparam logic [1:0] ALU_RI   = 2'b10;

  // Reg-reg funct codes
  localparam logic [3:0] FN_ADD = 4'h0;
  localparam logic [3:0] FN_SUB = 4'h1;
  localparam logic [3:0] FN_AND = 4'h2;
  localparam logic [3:0] FN_OR  = 4'h3;
  localparam logic [3:0] FN_XOR = 4'h4;
  localparam logic [3:0] FN_NOT = 4'h5;
  localparam logic [3:0] FN_SHL = 4'h6;
  localparam logic [3:0] FN_SHR = 4'h7;

  // Flag bit positions within {C, V, N, Z}
  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [2:0] {
    ST_START0    = 3'd0,
    ST_START1    = 3'd1,
    ST_FETCH     = 3'd2,
    ST_DECODE    = 3'd3,
    ST_EXECUTE   = 3'd4,
    ST_MEM       = 3'd5,
    ST_WRITEBACK = 3'd6,
    ST_HALT      = 3'd7
  } state_e;

  // Instruction word; funct is imm[3:0], rt is imm[15:12]
  typedef struct packed {
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
  } instr_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational 32-bit ALU with {C, V, N, Z} flag generation.
module exec_alu
  import sisc_pkg::*;
(
  input  logic [1:0]        alu_op,
  input  logic [3:0]        funct,
  input  logic [XLEN-1:0]   rsa,
  input  logic [XLEN-1:0]   rsb,
  input  logic [ALEN-1:0]   imm,
  output logic [XLEN-1:0]   result,
  output logic [FLAG_W-1:0] stat
);

  logic [XLEN-1:0] b_eff;
  logic            cin;
  logic            arith;
  logic [XLEN:0]   sum;

  // Shared adder: add, sub (rsa + ~rsb + 1) and reg-imm add
  assign sum = (XLEN+1)'(rsa) + (XLEN+1)'(b_eff) + (XLEN+1)'(cin);

  // Operation select
  always_comb begin
    b_eff  = rsb;
    cin    = 1'b0;
    arith  = 1'b0;
    result = '0;
    unique case (alu_op)
      ALU_RR: begin
        unique case (funct)
          FN_ADD: begin arith = 1'b1; result = sum[XLEN-1:0]; end
          FN_SUB: begin arith = 1'b1; b_eff = ~rsb; cin = 1'b1; result = sum[XLEN-1:0]; end
          FN_AND: result = rsa & rsb;
          FN_OR:  result = rsa | rsb;
          FN_XOR: result = rsa ^ rsb;
          FN_NOT: result = ~rsa;
          FN_SHL: result = rsa << rsb[4:0];
          FN_SHR: result = rsa >> rsb[4:0];
          default: result = rsa;
        endcase
      end
      ALU_RI: begin
        arith  = 1'b1;
        b_eff  = {{(XLEN-ALEN){imm[ALEN-1]}}, imm};
        result = sum[XLEN-1:0];
      end
      default: result = '0;
    endcase
  end

  // Flags; carry/overflow only meaningful for adder operations
  always_comb begin
    stat         = '0;
    stat[FLAG_Z] = (result == '0);
    stat[FLAG_N] = result[XLEN-1];
    stat[FLAG_C] = arith & sum[XLEN];
    stat[FLAG_V] = arith & (rsa[XLEN-1] == b_eff[XLEN-1]) & (sum[XLEN-1] != rsa[XLEN-1]);
  end

endmodule

// File: rtl/sisc_exec_ctrl.sv
// SISC execution/control core: sequencing FSM, ALU and branch-target calculator.
module sisc_exec_ctrl
  import sisc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_f,
  input  logic [31:0]       instr,
  input  logic [3:0]        stat_out,
  input  logic [31:0]       rsa,
  input  logic [31:0]       rsb,
  input  logic [15:0]       pc_out,
  output logic              rf_we,
  output logic [1:0]        alu_op,
  output logic              wb_sel,
  output logic              br_sel,
  output logic              pc_sel,
  output logic              ir_load,
  output logic              pc_write,
  output logic              pc_rst,
  output logic              rb_sel,
  output logic [31:0]       alu_result,
  output logic [3:0]        stat,
  output logic              stat_en,
  output logic [15:0]       br_addr
);

  state_e state_q, state_d;
  instr_t ir;
  logic [7:0] unused_regs;

  logic       is_alu, is_branch, is_abs, is_neg, is_hlt;
  logic [1:0] alu_mode;
  logic       flag_hit, br_taken;

  assign ir          = instr_t'(instr);
  assign unused_regs = {ir.rd, ir.rs};

  // Opcode decode
  always_comb begin
    is_alu    = 1'b0;
    is_branch = 1'b0;
    is_abs    = 1'b0;
    is_neg    = 1'b0;
    is_hlt    = 1'b0;
    alu_mode  = ALU_IDLE;
    case (ir.opcode)
      OP_ALU_RR: begin is_alu = 1'b1; alu_mode = ALU_RR; end
      OP_ALU_RI: begin is_alu = 1'b1; alu_mode = ALU_RI; end
      OP_BRA:    begin is_branch = 1'b1; is_abs = 1'b1; end
      OP_BRR:    is_branch = 1'b1;
      OP_BNE:    begin is_branch = 1'b1; is_abs = 1'b1; is_neg = 1'b1; end
      OP_BNR:    begin is_branch = 1'b1; is_neg = 1'b1; end
      OP_HLT:    is_hlt = 1'b1;
      OP_NOP:    ;
      default:   ;
    endcase
  end

  // Branch condition from mask and current flags
  assign flag_hit = |(ir.mm & stat_out);
  assign br_taken = is_neg ? ~flag_hit : ((ir.mm == 4'h0) | flag_hit);

  // Branch target: absolute imm or pc_out + imm with 16-bit wrap
  assign br_addr = br_sel ? ir.imm : ALEN'(pc_out + ir.imm);

  // State register
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state_q <= ST_START0;
    else        state_q <= state_d;
  end

  // Next-state and control outputs
  always_comb begin
    state_d  = state_q;
    rf_we    = 1'b0;
    alu_op   = ALU_IDLE;
    wb_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_sel   = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_rst   = 1'b0;
    rb_sel   = 1'b0;
    stat_en  = 1'b0;
    case (state_q)
      ST_START0: begin
        pc_rst  = 1'b1;
        state_d = ST_START1;
      end
      ST_START1: state_d = ST_FETCH;
      ST_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_branch) begin
          br_sel = is_abs;
          if (br_taken) begin
            pc_sel   = 1'b1;
            pc_write = 1'b1;
          end
        end
        state_d = is_hlt ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (is_alu) begin
          alu_op  = alu_mode;
          stat_en = 1'b1;
        end
        state_d = ST_MEM;
      end
      ST_MEM: state_d = ST_WRITEBACK;
      ST_WRITEBACK: begin
        if (is_alu) begin
          alu_op = alu_mode;
          rf_we  = 1'b1;
        end
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_START0;
    endcase
  end

  exec_alu u_alu (
    .alu_op (alu_op),
    .funct  (ir.imm[3:0]),
    .rsa    (rsa),
    .rsb    (rsb),
    .imm    (ir.imm),
    .result (alu_result),
    .stat   (stat)
  );

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// Directed bench for sisc_exec_ctrl.
module tb_sisc_exec_ctrl;

  logic        clk;
  logic        rst_f;
  logic [31:0] instr;
  logic [3:0]  stat_out;
  logic [31:0] rsa;
  logic [31:0] rsb;
  logic [15:0] pc_out;
  logic        rf_we;
  logic [1:0]  alu_op;
  logic        wb_sel;
  logic        br_sel;
  logic        pc_sel;
  logic        ir_load;
  logic        pc_write;
  logic        pc_rst;
  logic        rb_sel;
  logic [31:0] alu_result;
  logic [3:0]  stat;
  logic        stat_en;
  logic [15:0] br_addr;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  sisc_exec_ctrl dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .instr      (instr),
    .stat_out   (stat_out),
    .rsa        (rsa),
    .rsb        (rsb),
    .pc_out     (pc_out),
    .rf_we      (rf_we),
    .alu_op     (alu_op),
    .wb_sel     (wb_sel),
    .br_sel     (br_sel),
    .pc_sel     (pc_sel),
    .ir_load    (ir_load),
    .pc_write   (pc_write),
    .pc_rst     (pc_rst),
    .rb_sel     (rb_sel),
    .alu_result (alu_result),
    .stat       (stat),
    .stat_en    (stat_en),
    .br_addr    (br_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_f    = 1'b0;
    instr    = 32'h0;
    stat_out = 4'h0;
    rsa      = 32'h0;
    rsb      = 32'h0;
    pc_out   = 16'h0;

    // In reset
    #12;
    check("rst_pc_rst", 32'(pc_rst), 32'd1);
    check("rst_ir_load", 32'(ir_load), 32'd0);
    check("rst_result", alu_result, 32'h0);
    check("rst_stat", 32'(stat), 32'h1);
    check("rst_ctrl", 32'({rf_we, alu_op, wb_sel, br_sel, pc_sel, pc_write, rb_sel, stat_en}), 32'h0);

    // Release: START0 -> START1 -> FETCH
    @(negedge clk);
    rst_f = 1'b1;
    #1;
    check("start0_pc_rst", 32'(pc_rst), 32'd1);
    tick();
    check("start1_pc_rst", 32'(pc_rst), 32'd0);
    check("start1_ir_load", 32'(ir_load), 32'd0);
    tick();

    // ADD 0x7FFFFFFF + 1
    instr = 32'h1012_3000; rsa = 32'h7FFF_FFFF; rsb = 32'h1;
    #1;
    check("add_fetch_ir_load", 32'(ir_load), 32'd1);
    check("add_fetch_pc_write", 32'(pc_write), 32'd1);
    check("add_fetch_pc_sel", 32'(pc_sel), 32'd0);
    tick();
    check("add_decode_pc_write", 32'(pc_write), 32'd0);
    check("add_decode_alu_op", 32'(alu_op), 32'd0);
    tick();
    check("add_exec_alu_op", 32'(alu_op), 32'd1);
    check("add_exec_result", alu_result, 32'h8000_0000);
    check("add_exec_stat", 32'(stat), 32'h6);
    check("add_exec_stat_en", 32'(stat_en), 32'd1);
    check("add_exec_rf_we", 32'(rf_we), 32'd0);
    tick();
    check("add_mem_stat_en", 32'(stat_en), 32'd0);
    check("add_mem_alu_op", 32'(alu_op), 32'd0);
    tick();
    check("add_wb_rf_we", 32'(rf_we), 32'd1);
    check("add_wb_result", alu_result, 32'h8000_0000);
    check("add_wb_stat_en", 32'(stat_en), 32'd0);
    check("add_wb_wb_sel", 32'(wb_sel), 32'd0);
    tick();

    // SUB 5 - 5
    instr = 32'h1012_3001; rsa = 32'd5; rsb = 32'd5;
    #1;
    check("sub_fetch_rf_we", 32'(rf_we), 32'd0);
    check("sub_fetch_ir_load", 32'(ir_load), 32'd1);
    tick(); tick();
    check("sub_exec_result", alu_result, 32'h0);
    check("sub_exec_stat", 32'(stat), 32'h9);
    tick(); tick(); tick();

    // Reg-imm 3 + sext(0xFFFF)
    instr = 32'h2010_FFFF; rsa = 32'd3;
    tick(); tick();
    check("ri_exec_alu_op", 32'(alu_op), 32'd2);
    check("ri_exec_result", alu_result, 32'h2);
    check("ri_exec_stat_en", 32'(stat_en), 32'd1);
    tick(); tick(); tick();

    // BRR mm=0001, Z=1: taken, relative target
    instr = 32'h5100_FFFC; stat_out = 4'b0001; pc_out = 16'h0010;
    tick();
    check("brr_br_addr", 32'(br_addr), 32'h000C);
    check("brr_br_sel", 32'(br_sel), 32'd0);
    check("brr_pc_sel", 32'(pc_sel), 32'd1);
    check("brr_pc_write", 32'(pc_write), 32'd1);
    tick();
    check("brr_exec_ctrl", 32'({pc_write, stat_en, alu_op}), 32'h0);
    tick(); tick();
    check("brr_wb_rf_we", 32'(rf_we), 32'd0);
    tick();

    // BNE mm=0001, Z=1: not taken, absolute target
    instr = 32'h6100_0020;
    tick();
    check("bne_br_sel", 32'(br_sel), 32'd1);
    check("bne_br_addr", 32'(br_addr), 32'h0020);
    check("bne_pc_sel", 32'(pc_sel), 32'd0);
    check("bne_pc_write", 32'(pc_write), 32'd0);
    tick(); tick(); tick(); tick();

    // BRA mm=0000: unconditional
    instr = 32'h4000_0040; stat_out = 4'b0000;
    tick();
    check("bra_br_addr", 32'(br_addr), 32'h0040);
    check("bra_pc_sel", 32'(pc_sel), 32'd1);
    tick(); tick(); tick(); tick();

    // BNR mm=0010, N=0: taken, relative
    instr = 32'h7200_0005; stat_out = 4'b1001; pc_out = 16'hFFFE;
    tick();
    check("bnr_br_addr", 32'(br_addr), 32'h0003);
    check("bnr_pc_sel", 32'(pc_sel), 32'd1);
    tick(); tick(); tick(); tick();

    // ADD abandoned by reset in EXECUTE; HLT waiting after restart
    instr = 32'h1012_3000; rsa = 32'd1; rsb = 32'd2;
    tick(); tick();
    check("abort_exec_stat_en", 32'(stat_en), 32'd1);
    rst_f = 1'b0;
    #1;
    check("abort_pc_rst", 32'(pc_rst), 32'd1);
    check("abort_stat_en", 32'(stat_en), 32'd0);
    check("abort_alu_op", 32'(alu_op), 32'd0);
    instr = 32'hF000_0000;
    @(negedge clk);
    rst_f = 1'b1;
    #1;
    check("restart_rf_we0", 32'(rf_we), 32'd0);
    tick();
    check("restart_rf_we1", 32'(rf_we), 32'd0);
    tick();
    check("restart_fetch", 32'(ir_load), 32'd1);
    tick();
    check("hlt_decode_rf_we", 32'(rf_we), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_quiet", 32'({ir_load, pc_write, pc_rst, rf_we, stat_en}), 32'h0);
    end

    // Reset leaves HALT
    rst_f = 1'b0;
    #1;
    check("halt_rst_pc_rst", 32'(pc_rst), 32'd1);
    @(negedge clk);
    rst_f = 1'b1;
    tick(); tick();
    check("halt_exit_fetch", 32'(ir_load), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
